seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed 8-digit seven-segment display controller driving the board SEG/NA pins from a 32-bit CPU value, e.g. a register or PC readout.
- Sits between the CPU core and the FPGA_OUTPUT_SEG / FPGA_OUTPUT_NA pins of the top-level shell.
- Accepts new display values via valid/ready and applies them only at frame boundaries, so a frame never mixes old and new digits.
- Inserts an anode-off guard interval at each digit switch to suppress ghosting.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot; legal range GUARD+1..2^20.
- GUARD, 2: cycles at the start of each slot with all anodes inactive; legal range 0..SCAN_DIV-1.
- ACTIVE_LOW, 1: 1 means seg_out and an_out are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- disp_data  in  32  value to display; nibble i is shown on digit i.
- disp_valid  in  1  disp_data offered.
- disp_ready  out  1  pending slot free; transfer occurs when disp_valid&&disp_ready.
- blank_mask  in  8  bit i=1 keeps digit i dark; sampled live.
- dp_mask  in  8  bit i=1 lights the decimal point on digit i; sampled live.
- seg_out  out  8  bits [6:0] = segments a..g, bit [7] = dp.
- an_out  out  8  bit i selects digit i.
- frame_done  out  1  one-cycle pulse at each digit 7 to digit 0 wrap.

Behaviour:
- Reset is synchronous: while rst=1, all state is held at its reset value on every clk edge.
  - prescaler=0, digit=0, shadow=0, pending empty.
  - seg_out and an_out at their inactive level: 8'hFF if ACTIVE_LOW=1, 8'h00 otherwise.
  - disp_ready=1, frame_done=0.
- Prescaler counts 0..SCAN_DIV-1 and wraps.
  - When the prescaler equals SCAN_DIV-1, digit increments on the same edge; 7 wraps to 0.
- Frame boundary: the edge on which digit goes 7 to 0.
  - On that edge, if pending is full: shadow <= pending and pending is cleared.
  - frame_done = 1 for exactly the following cycle.
- Handshake:
  - disp_ready = !pending_full, driven combinationally from the register.
  - On accept, pending <= disp_data on that edge.
  - A second word while pending is full is back-pressured (disp_ready=0) until the next frame boundary.
  - Accept on a boundary edge while pending is empty: the word goes into pending, and shadow takes it at the following boundary.
  - disp_data is don't-care when disp_valid=0.
- Output register, updated every cycle and valid one cycle after the prescaler/digit state it reflects:
  - If prescaler < GUARD, or blank_mask[digit]=1: an_out is all inactive and seg_out is all inactive.
  - Otherwise an_out is one-hot on bit digit, and seg_out = {dp_mask[digit], font(shadow[4*digit+3:4*digit])}.
  - Polarity is applied per ACTIVE_LOW.
- Font, bits g..a in active-high form:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- No multi-hot anodes are ever driven, including on the first cycle after reset.
- rst asserted mid-frame:
  - Abandons the current frame and discards the pending word.
  - Next frame starts at digit 0 showing 0.
  - No frame_done pulse is produced by the reset.

Test Plan:
- Reset, SCAN_DIV=4, GUARD=1, ACTIVE_LOW=1: hold rst 3 cycles -> seg_out=FF, an_out=FF, disp_ready=1, frame_done=0.
  - After release: an_out stays FF for one guard cycle, then shows FE with seg_out=C0 (digit 0 = '0').
- Scan order: accept 32'h89ABCDEF, wait one frame -> each slot shows 1 guard cycle then 3 active cycles.
  - an_out steps FE, FD, FB, ... 7F.
  - digit0 seg=8E (F), digit7 seg=80 (8).
  - frame_done pulses once per 32 cycles.
- Back-pressure: accept A, then hold disp_valid=1 with B mid-frame -> disp_ready=0 until the boundary.
  - A is shown the next frame; B is accepted on the cycle after the boundary and shown one frame later.
  - No torn frame.
- Masks: blank_mask=8'h0F, dp_mask=8'h80 -> digits 0-3 never drive anodes; digit 7 seg_out bit7=0 (dp lit).
- Reset mid-frame: assert rst at digit 5 with pending full -> pending dropped, shadow=0, digit restarts at 0, no frame_done.
- ACTIVE_LOW=0, SCAN_DIV=2, GUARD=0: shows 0x00000001 -> digit0 an_out=01, seg_out=06; digits 1-7 seg_out=3F; anodes never off between slots.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner. A 32-bit value is latched at
// frame boundaries only, and each digit slot opens with an anode-off guard.
module seg_scan_ctrl #(
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_data,
  input  logic        disp_valid,
  output logic        disp_ready,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  seg_out,
  output logic [7:0]  an_out,
  output logic        frame_done
);

  localparam int               CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [7:0]       INACTIVE   = ACTIVE_LOW ? 8'hFF : 8'h00;

  function automatic logic [6:0] font7(input logic [3:0] nib);
    logic [6:0] f;
    case (nib)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  function automatic logic [7:0] to_pins(input logic [7:0] active_high);
    return ACTIVE_LOW ? ~active_high : active_high;
  endfunction

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [2:0]       digit_q, digit_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;

  logic             in_guard;
  logic             presc_wrap;
  logic             frame_wrap;
  logic             accept;
  logic [3:0]       nib;
  logic [7:0]       seg_ah;
  logic [7:0]       an_ah;

  // With no guard the comparison would be constant-false, so it is not built.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (presc_q < CNT_W'(GUARD));
    end
  endgenerate

  always_comb begin
    presc_wrap   = (presc_q == PRESC_LAST);
    frame_wrap   = presc_wrap && (digit_q == 3'd7);
    accept       = disp_valid && !pend_full_q;

    presc_d      = presc_wrap ? '0 : presc_q + 1'b1;
    digit_d      = presc_wrap ? digit_q + 3'd1 : digit_q;
    frame_done_d = frame_wrap;

    shadow_d     = shadow_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    // A full pending slot blocks accept, so swap and accept never collide.
    if (frame_wrap && pend_full_q) begin
      shadow_d    = pend_q;
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_d      = disp_data;
      pend_full_d = 1'b1;
    end

    nib    = shadow_q[{digit_q, 2'b00} +: 4];
    seg_ah = 8'h00;
    an_ah  = 8'h00;
    if (!in_guard && !blank_mask[digit_q]) begin
      an_ah  = 8'd1 << digit_q;
      seg_ah = {dp_mask[digit_q], font7(nib)};
    end
    seg_d = to_pins(seg_ah);
    an_d  = to_pins(an_ah);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      digit_q      <= 3'd0;
      shadow_q     <= 32'h0;
      pend_q       <= 32'h0;
      pend_full_q  <= 1'b0;
      seg_q        <= INACTIVE;
      an_q         <= INACTIVE;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign disp_ready = !pend_full_q;
  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;

endmodule
